peripheral_display_scan: RTL and testbench

Time-multiplexed scanner for a 4-digit common-anode 7-segment display. Holds a 16-bit display value written by the bus-side peripheral logic and presents one nibble at a time on `digit_code`, which feeds `peripheral_deco7seg.D` directly. It drives the matching active-low anode enable. Updates are double-buffered and applied only at frame boundaries, so the display never shows a mix of old and new digits.

---
 rtl/peripheral_display_scan.sv | 123 ++++++++++++
 tb/tb_peripheral_display_scan.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_display_scan.sv
// Four-digit 7-segment scanner: one nibble and one active-low anode per slot,
// with display updates double-buffered to frame boundaries.
module peripheral_display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [15:0] wr_data,
  input  logic        blank_lz,
  output logic [3:0]  digit_code,
  output logic [3:0]  an,
  output logic        upd_pending,
  output logic        frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_v_q, pend_v_d;
  logic [3:0]    digit_code_q, digit_code_d;
  logic [3:0]    an_q, an_d;
  logic          frame_tick_q, frame_tick_d;
  logic          slot_end_s;
  logic          boundary_s;
  logic [3:0]    nib_s;

  // Digit i is a leading zero when every nibble from 3 down to i is zero.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] i);
    logic b;
    case (i)
      2'd0:    b = 1'b0;
      2'd1:    b = (v[15:4] == 12'h000);
      2'd2:    b = (v[15:8] == 8'h00);
      2'd3:    b = (v[15:12] == 4'h0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction

  always_comb begin
    slot_end_s = (div_cnt_q == DIV_LAST);
    boundary_s = slot_end_s && (idx_q == 2'd3);

    if (slot_end_s) begin
      div_cnt_d = '0;
      idx_d     = idx_q + 2'd1;
    end else begin
      div_cnt_d = div_cnt_q + CW'(1);
      idx_d     = idx_q;
    end

    disp_d   = disp_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    // A write landing on the boundary bypasses the pending buffer.
    if (boundary_s) begin
      if (wr_en) begin
        disp_d   = wr_data;
        pend_v_d = 1'b0;
      end else if (pend_v_q) begin
        disp_d   = pend_q;
        pend_v_d = 1'b0;
      end else begin
        disp_d   = disp_q;
      end
    end else if (wr_en) begin
      pend_d   = wr_data;
      pend_v_d = 1'b1;
    end else begin
      pend_v_d = pend_v_q;
    end

    nib_s = disp_q[{idx_q, 2'b00} +: 4];
    if (blank_lz && lz_blank(disp_q, idx_q)) begin
      digit_code_d = 4'hF;
    end else begin
      digit_code_d = nib_s;
    end

    if (div_cnt_q < GUARD_C) begin
      an_d = 4'b1111;
    end else begin
      an_d = ~(4'b0001 << idx_q);
    end

    frame_tick_d = boundary_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q    <= '0;
      idx_q        <= 2'd0;
      disp_q       <= 16'hEEEE;
      pend_q       <= 16'h0000;
      pend_v_q     <= 1'b0;
      digit_code_q <= 4'hF;
      an_q         <= 4'b1111;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_v_q     <= pend_v_d;
      digit_code_q <= digit_code_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign digit_code  = digit_code_q;
  assign an          = an_q;
  assign upd_pending = pend_v_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_peripheral_display_scan.sv
// Scoreboard bench for peripheral_display_scan: stimulus pushes the expected
// anode/code pair of every lit slot, a monitor pops one at each slot start.
module tb_peripheral_display_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit_code;
  logic [3:0]  an;
  logic        upd_pending;
  logic        frame_tick;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] code;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  int         run = 0;
  int         cyc = 0;
  bit         have_tick = 1'b0;
  logic [3:0] an_prev = 4'hF;
  exp_t       e;

  peripheral_display_scan #(.REFRESH_DIV(4), .GUARD(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .blank_lz(blank_lz), .digit_code(digit_code), .an(an),
    .upd_pending(upd_pending), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // codes holds the expected digit_code of digit i in nibble i
  task automatic push_frame(input logic [15:0] codes);
    sb_q.push_back({4'b1110, codes[3:0]});
    sb_q.push_back({4'b1101, codes[7:4]});
    sb_q.push_back({4'b1011, codes[11:8]});
    sb_q.push_back({4'b0111, codes[15:12]});
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 40);
    if (frame_tick !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no frame_tick within %0d cycles", n);
    end
  endtask

  task automatic do_write(input logic [15:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // Monitor: slot-start compare against the scoreboard, lit length, tick period.
  always @(negedge clk) begin
    if (!rst_n) begin
      run       = 0;
      cyc       = 0;
      have_tick = 1'b0;
      an_prev   = 4'hF;
    end else begin
      cyc++;
      if (frame_tick) begin
        if (have_tick) check("tick_period", 16'(cyc), 16'd16);
        have_tick = 1'b1;
        cyc       = 0;
      end
      if (an != 4'hF) begin
        if (an_prev == 4'hF) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: an=%b code=%h with no expectation", an, digit_code);
          end else begin
            e = sb_q.pop_front();
            check("slot_an", {12'h000, an}, {12'h000, e.an});
            check("slot_code", {12'h000, digit_code}, {12'h000, e.code});
          end
        end
        run++;
      end else begin
        if (run > 0) check("lit_len", 16'(run), 16'd3);
        run = 0;
      end
      an_prev = an;
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    skip(2);
    check("rst_an", {12'h000, an}, 16'h000F);
    check("rst_code", {12'h000, digit_code}, 16'h000F);
    check("rst_upd", {15'h0, upd_pending}, 16'h0000);
    check("rst_tick", {15'h0, frame_tick}, 16'h0000);
    push_frame(16'hEEEE);
    rst_n = 1'b1;

    wait_tick();
    push_frame(16'hEEEE);
    skip(3);
    do_write(16'h12A7);
    check("upd_after_wr", {15'h0, upd_pending}, 16'h0001);

    wait_tick();
    check("upd_drop", {15'h0, upd_pending}, 16'h0000);
    push_frame(16'h12A7);
    skip(2);
    do_write(16'h1111);
    skip(2);
    do_write(16'h2222);
    check("upd_two_wr", {15'h0, upd_pending}, 16'h0001);

    wait_tick();
    push_frame(16'h2222);
    skip(15);
    wr_en   = 1'b1;
    wr_data = 16'h5678;
    check("upd_pre_bnd", {15'h0, upd_pending}, 16'h0000);

    wait_tick();
    wr_en = 1'b0;
    check("upd_bnd_wr", {15'h0, upd_pending}, 16'h0000);
    push_frame(16'h5678);
    skip(3);
    check("upd_bnd_wr_later", {15'h0, upd_pending}, 16'h0000);
    do_write(16'h0030);

    wait_tick();
    blank_lz = 1'b1;
    push_frame(16'hFF30);
    skip(3);
    do_write(16'h0000);

    wait_tick();
    push_frame(16'hFFF0);
    skip(3);
    do_write(16'h0300);

    wait_tick();
    push_frame(16'hF300);
    skip(3);
    do_write(16'h0000);

    wait_tick();
    blank_lz = 1'b0;
    push_frame(16'h0000);
    skip(3);
    do_write(16'hBEEF);
    check("upd_before_rst", {15'h0, upd_pending}, 16'h0001);
    skip(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_an", {12'h000, an}, 16'h000F);
    check("arst_code", {12'h000, digit_code}, 16'h000F);
    check("arst_upd", {15'h0, upd_pending}, 16'h0000);
    check("arst_tick", {15'h0, frame_tick}, 16'h0000);
    sb_q.delete();
    skip(3);
    push_frame(16'hEEEE);
    rst_n = 1'b1;

    wait_tick();
    check("upd_post_rst", {15'h0, upd_pending}, 16'h0000);
    push_frame(16'hEEEE);

    wait_tick();
    check("upd_final", {15'h0, upd_pending}, 16'h0000);
    check("sb_empty", 16'(sb_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
